mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM-stage load/store unit between the EX/MEM register and mem_wb.
- Converts the EX result (address) and store data into a byte-enabled data-memory request with a variable-latency ready handshake.
- Aligns and sign-/zero-extends load data and registers the writeback bundle that mem_wb samples.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before the transaction is abandoned with bus_err.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single pipeline clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- rd_from_ex  in  5  destination register.
- write_reg_from_ex  in  1  instruction writes rd.
- read_mem_from_ex  in  1  load.
- write_mem_from_ex  in  1  store.
- funct3_from_ex  in  3  width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- result_from_ex  in  32  ALU result; the effective address for memory ops.
- store_data_from_ex  in  32  rs2 value.
- mem_req  out  1  data-memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory completes the request this cycle.
- mem_rdata  in  32  read word, valid when mem_ready=1.
- stall_out  out  1  upstream must hold.
- rd_to_wb  out  5  to mem_wb rd_from_mem.
- write_reg_to_wb  out  1  to mem_wb write_reg_from_mem.
- read_mem_to_wb  out  1  to mem_wb read_mem_from_mem.
- result_to_wb  out  32  to mem_wb result_from_mem.
- load_data_to_wb  out  32  to mem_wb data_from_mem_from_mem.
- out_valid  out  1  writeback bundle valid this cycle.
- misalign  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: timeout.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-low.
- Reset state: when rst=0 at a rising edge, state=IDLE, counter=0, and all outputs are 0, including mem_req and stall_out.
- Reset mid-transaction: the request is abandoned and mem_req=0 from the next cycle; a late mem_ready is ignored.
- FSM states: IDLE and WAIT. stall_out = (state==WAIT), combinational.
- IDLE, in_valid=0: next cycle out_valid=0 and write_reg_to_wb=0 (bubble). write_reg_to_wb is forced to 0 whenever out_valid=0.
- IDLE, non-memory op (neither read_mem nor write_mem): one-cycle registered pass-through.
  - out_valid=1; rd, write_reg and result copied; read_mem_to_wb=0; load_data_to_wb=0.
- IDLE, memory op, misaligned: h/hu with addr[0]=1, or w with addr[1:0]≠0.
  - No request is issued.
  - Next cycle: out_valid=1, write_reg_to_wb=0, misalign=1.
- IDLE, memory op, aligned: latch the op and go to WAIT.
  - From the next cycle mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata held stable until completion.
- Byte enables and store data:
  - b: be = 4'b0001 << addr[1:0]; wdata = byte replicated 4×.
  - h: be = 4'b0011 or 4'b1100 by addr[1]; wdata = half replicated 2×.
  - w: be = 4'b1111.
  - Loads drive the same be; mem_we=0.
- WAIT, mem_ready=1: completion in the same cycle as the edge.
  - Next cycle: state=IDLE, mem_req=0, out_valid=1, result_to_wb=address.
  - Load: load_data_to_wb = selected byte/half shifted down by addr[1:0], sign-extended for b/h and zero-extended for bu/hu; read_mem_to_wb=1; write_reg as latched.
  - Store: write_reg_to_wb=0, read_mem_to_wb=0.
- WAIT, mem_ready=0: counter increments each cycle.
  - When counter reaches TIMEOUT_CYCLES-1 without ready, return to IDLE: mem_req=0, out_valid=1, write_reg_to_wb=0, bus_err=1.
- mem_ready while IDLE: ignored.
- Latency: minimum load/store latency is 2 cycles from acceptance to out_valid (zero-wait memory). Each extra wait cycle adds one.
- Back-to-back memory ops: a new op is accepted in the IDLE cycle right after completion; there is no dead cycle beyond the stall.
- rd=x0: passed through unchanged; the register file ignores writes to x0.

Decomposition:
- Shared package (riscv_pkg): funct3 load/store width codes and FSM state encoding.
- One natural sub-module, load_align: combinational (mem_rdata, addr[1:0], funct3) → aligned 32-bit extended data. Store byte-enable and data replication stay inline.

Test Plan:
- Zero-wait load: lw addr 0x100, rdata 0xDEADBEEF, mem_ready on the first WAIT cycle → stall_out high 1 cycle; out_valid with load_data_to_wb=0xDEADBEEF and read_mem_to_wb=1 two cycles after acceptance.
- Byte/half extension: rdata 0x80F17F00.
  - lb addr 0x203 → 0xFFFFFF80; lbu addr 0x203 → 0x00000080.
  - lh addr 0x202 → 0xFFFF80F1; lhu addr 0x200 → 0x00007F00.
- Store lanes: sb data 0x000000AB addr 0x301 → mem_be=0010, mem_wdata=0xABABABAB, mem_we=1; 3 wait cycles → stall_out high 4 cycles, then out_valid with write_reg_to_wb=0.
- Misaligned and timeout:
  - lw addr 0x102 → no mem_req; misalign pulse with write_reg_to_wb=0.
  - mem_ready held 0 → bus_err pulse after 16 WAIT cycles; mem_req drops.
- ALU op and reset:
  - ALU op rd=5 result=0x1234 → next cycle out_valid=1, rd_to_wb=5, write_reg_to_wb=1, result_to_wb=0x1234.
  - rst=0 during WAIT → all outputs 0 after the edge; a later mem_ready causes no out_valid.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// riscv_pkg: load/store width codes, MEM-stage FSM encoding, lane helpers
// Rev 1.0
// ------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = addr_lo[0];
      default: r = (addr_lo != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{data[7:0]}};
      SZ_H:    w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ------------------------------------------------------------------
// load_align: select byte/half from a read word and sign/zero-extend
// Rev 1.0
// ------------------------------------------------------------------
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{addr_lo, 3'b000} +: 8];
    sel_half = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   data = {24'd0, sel_byte};
      F3_H:    data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   data = {16'd0, sel_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_access: MEM-stage load/store unit with variable-latency ready handshake
// Rev 1.0
// ------------------------------------------------------------------
module mem_access
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  rd_from_ex,
  input  logic        write_reg_from_ex,
  input  logic        read_mem_from_ex,
  input  logic        write_mem_from_ex,
  input  logic [2:0]  funct3_from_ex,
  input  logic [31:0] result_from_ex,
  input  logic [31:0] store_data_from_ex,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic [4:0]  rd_to_wb,
  output logic        write_reg_to_wb,
  output logic        read_mem_to_wb,
  output logic [31:0] result_to_wb,
  output logic [31:0] load_data_to_wb,
  output logic        out_valid,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op_addr;
  logic [2:0]       op_f3;
  logic [4:0]       op_rd;
  logic             op_wr;
  logic             op_load;
  logic [31:0]      aligned_data;
  logic             is_mem;
  logic [1:0]       size;

  assign is_mem    = read_mem_from_ex | write_mem_from_ex;
  assign size      = funct3_from_ex[1:0];
  assign stall_out = (state == S_WAIT);

  load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (op_addr[1:0]),
    .funct3  (op_f3),
    .data    (aligned_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      op_addr         <= '0;
      op_f3           <= '0;
      op_rd           <= '0;
      op_wr           <= 1'b0;
      op_load         <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_be          <= '0;
      mem_wdata       <= '0;
      rd_to_wb        <= '0;
      write_reg_to_wb <= 1'b0;
      read_mem_to_wb  <= 1'b0;
      result_to_wb    <= '0;
      load_data_to_wb <= '0;
      out_valid       <= 1'b0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      // Writeback bundle is a bubble unless a branch below fills it.
      rd_to_wb        <= '0;
      write_reg_to_wb <= 1'b0;
      read_mem_to_wb  <= 1'b0;
      result_to_wb    <= '0;
      load_data_to_wb <= '0;
      out_valid       <= 1'b0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;

      if (state == S_WAIT) begin
        if (mem_ready) begin
          state        <= S_IDLE;
          mem_req      <= 1'b0;
          mem_we       <= 1'b0;
          mem_addr     <= '0;
          mem_be       <= '0;
          mem_wdata    <= '0;
          out_valid    <= 1'b1;
          rd_to_wb     <= op_rd;
          result_to_wb <= op_addr;
          if (op_load) begin
            write_reg_to_wb <= op_wr;
            read_mem_to_wb  <= 1'b1;
            load_data_to_wb <= aligned_data;
          end
        end else if (cnt == LAST_CNT) begin
          state        <= S_IDLE;
          mem_req      <= 1'b0;
          mem_we       <= 1'b0;
          mem_addr     <= '0;
          mem_be       <= '0;
          mem_wdata    <= '0;
          out_valid    <= 1'b1;
          bus_err      <= 1'b1;
          rd_to_wb     <= op_rd;
          result_to_wb <= op_addr;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (in_valid) begin
        if (!is_mem) begin
          out_valid       <= 1'b1;
          rd_to_wb        <= rd_from_ex;
          write_reg_to_wb <= write_reg_from_ex;
          result_to_wb    <= result_from_ex;
        end else if (is_misaligned(size, result_from_ex[1:0])) begin
          out_valid    <= 1'b1;
          misalign     <= 1'b1;
          rd_to_wb     <= rd_from_ex;
          result_to_wb <= result_from_ex;
        end else begin
          state     <= S_WAIT;
          cnt       <= '0;
          op_addr   <= result_from_ex;
          op_f3     <= funct3_from_ex;
          op_rd     <= rd_from_ex;
          op_wr     <= write_reg_from_ex;
          op_load   <= read_mem_from_ex & ~write_mem_from_ex;
          mem_req   <= 1'b1;
          mem_we    <= write_mem_from_ex;
          mem_addr  <= {result_from_ex[31:2], 2'b00};
          mem_be    <= byte_en(size, result_from_ex[1:0]);
          mem_wdata <= store_lanes(size, store_data_from_ex);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mem_access: randomized scoreboard bench for the MEM-stage unit
// Rev 1.0
// ------------------------------------------------------------------
module tb_mem_access;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  rd_from_ex;
  logic        write_reg_from_ex;
  logic        read_mem_from_ex;
  logic        write_mem_from_ex;
  logic [2:0]  funct3_from_ex;
  logic [31:0] result_from_ex;
  logic [31:0] store_data_from_ex;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall_out;
  logic [4:0]  rd_to_wb;
  logic        write_reg_to_wb;
  logic        read_mem_to_wb;
  logic [31:0] result_to_wb;
  logic [31:0] load_data_to_wb;
  logic        out_valid;
  logic        misalign;
  logic        bus_err;

  mem_access #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .rd_from_ex(rd_from_ex), .write_reg_from_ex(write_reg_from_ex),
    .read_mem_from_ex(read_mem_from_ex), .write_mem_from_ex(write_mem_from_ex),
    .funct3_from_ex(funct3_from_ex), .result_from_ex(result_from_ex),
    .store_data_from_ex(store_data_from_ex),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_out(stall_out), .rd_to_wb(rd_to_wb), .write_reg_to_wb(write_reg_to_wb),
    .read_mem_to_wb(read_mem_to_wb), .result_to_wb(result_to_wb),
    .load_data_to_wb(load_data_to_wb), .out_valid(out_valid),
    .misalign(misalign), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_MIS, K_BERR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] result;
    logic [31:0] ldata;
  } exp_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  resp_en = 1'b1;
  logic  force_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: widths in bytes, arithmetic shifts/masks.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int n;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    n   = nbytes(f3);
    off = int'(addr[1:0]);
    if (n == 4) return word;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = (word >> (8 * off)) & mask;
    if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input int n);
    if (n == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  task automatic push_exp(input kind_t k, input logic [4:0] rd, input logic wr,
                          input logic [31:0] res, input logic [31:0] ld);
    exp_t e;
    e.kind = k; e.rd = rd; e.wr = wr; e.result = res; e.ldata = ld;
    exp_q.push_back(e);
  endtask

  // op: 0 = ALU, 1 = load, 2 = store. Called at a negedge with stall_out low.
  task automatic issue(input logic iv, input int op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic wr, input logic [31:0] addr, input logic [31:0] sdata,
                       input int lat, input logic [31:0] rdata);
    int n;
    plan_t p;
    in_valid           = iv;
    rd_from_ex         = rd;
    write_reg_from_ex  = wr;
    read_mem_from_ex   = (op == 1);
    write_mem_from_ex  = (op == 2);
    funct3_from_ex     = f3;
    result_from_ex     = addr;
    store_data_from_ex = sdata;
    if (!iv) return;
    if (op == 0) begin
      push_exp(K_ALU, rd, wr, addr, 32'd0);
      return;
    end
    n = nbytes(f3);
    if ((addr % n) != 0) begin
      push_exp(K_MIS, rd, 1'b0, addr, 32'd0);
      return;
    end
    p.we    = (op == 2);
    p.addr  = addr - (addr % 4);
    p.be    = 4'(((1 << n) - 1) << (addr % 4));
    p.wdata = model_wdata(sdata, n);
    p.lat   = lat;
    p.rdata = rdata;
    plan_q.push_back(p);
    if (lat >= TIMEOUT)  push_exp(K_BERR, rd, 1'b0, addr, 32'd0);
    else if (op == 1)    push_exp(K_LOAD, rd, wr, addr, model_load(rdata, addr, f3));
    else                 push_exp(K_STORE, rd, 1'b0, addr, 32'd0);
  endtask

  task automatic slot();
    int n;
    n = 0;
    @(negedge clk);
    while (stall_out && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("stall_bound", 32'd1, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),         32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),          32'd0);
    chk({tag, "_mem_addr"},  mem_addr,             32'd0);
    chk({tag, "_mem_be"},    32'(mem_be),          32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,            32'd0);
    chk({tag, "_stall"},     32'(stall_out),       32'd0);
    chk({tag, "_rd"},        32'(rd_to_wb),        32'd0);
    chk({tag, "_wr"},        32'(write_reg_to_wb), 32'd0);
    chk({tag, "_rm"},        32'(read_mem_to_wb),  32'd0);
    chk({tag, "_result"},    result_to_wb,         32'd0);
    chk({tag, "_ldata"},     load_data_to_wb,      32'd0);
    chk({tag, "_valid"},     32'(out_valid),       32'd0);
    chk({tag, "_misalign"},  32'(misalign),        32'd0);
    chk({tag, "_bus_err"},   32'(bus_err),         32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the writeback bundle is valid.
  exp_t mon_e;
  always @(negedge clk) begin
    chk("stall_eq_req", 32'(stall_out), 32'(mem_req));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_write_reg", 32'(write_reg_to_wb),
            32'((mon_e.kind == K_ALU || mon_e.kind == K_LOAD) ? mon_e.wr : 1'b0));
        chk("wb_misalign", 32'(misalign), 32'(mon_e.kind == K_MIS));
        chk("wb_bus_err",  32'(bus_err),  32'(mon_e.kind == K_BERR));
        if (mon_e.kind == K_ALU || mon_e.kind == K_LOAD) begin
          chk("wb_rd",       32'(rd_to_wb),       32'(mon_e.rd));
          chk("wb_result",   result_to_wb,        mon_e.result);
          chk("wb_read_mem", 32'(read_mem_to_wb), 32'(mon_e.kind == K_LOAD));
          chk("wb_ldata",    load_data_to_wb,     mon_e.ldata);
        end else if (mon_e.kind == K_STORE) begin
          chk("wb_st_result",   result_to_wb,        mon_e.result);
          chk("wb_st_read_mem", 32'(read_mem_to_wb), 32'd0);
        end
      end
    end else begin
      chk("bubble_write_reg", 32'(write_reg_to_wb), 32'd0);
      chk("bubble_misalign",  32'(misalign),        32'd0);
      chk("bubble_bus_err",   32'(bus_err),         32'd0);
    end
  end

  // Memory responder: serves planned requests with their planned latency.
  plan_t cur;
  logic  resp_active = 1'b0;
  logic  expect_drop = 1'b0;
  int    cyc = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = $urandom();
    if (!resp_en) begin
      mem_ready   = force_ready;
      resp_active = 1'b0;
      expect_drop = 1'b0;
    end else begin
      if (expect_drop) begin
        chk("req_drop_after_ready", 32'(mem_req), 32'd0);
        chk("valid_after_ready",    32'(out_valid), 32'd1);
        expect_drop = 1'b0;
      end else if (!mem_req && resp_active) begin
        chk("timeout_wait_cycles", 32'(cyc), 32'(TIMEOUT));
        chk("timeout_planned",     32'(cur.lat >= TIMEOUT), 32'd1);
        chk("timeout_bus_err",     32'(bus_err), 32'd1);
        resp_active = 1'b0;
      end
      if (mem_req) begin
        if (!resp_active) begin
          if (plan_q.size() == 0) begin
            chk("unexpected_mem_req", 32'd1, 32'd0);
          end else begin
            cur = plan_q.pop_front();
            resp_active = 1'b1;
            cyc = 0;
          end
        end
        if (resp_active) begin
          cyc++;
          chk("req_we",   32'(mem_we), 32'(cur.we));
          chk("req_addr", mem_addr,    cur.addr);
          chk("req_be",   32'(mem_be), 32'(cur.be));
          if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
          if (cyc - 1 == cur.lat) begin
            mem_ready   = 1'b1;
            mem_rdata   = cur.rdata;
            resp_active = 1'b0;
            expect_drop = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [2:0]  load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [31:0] ra;
  logic [31:0] rdat;
  int          r;
  int          kind;
  int          lat;
  int          n;
  logic [2:0]  f3;

  initial begin
    rst = 1'b0;
    issue(1'b0, 0, 3'd0, 5'd0, 1'b0, 32'd0, 32'd0, 0, 32'd0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Directed cases
    slot(); issue(1'b1, 1, 3'b010, 5'd1, 1'b1, 32'h100, 32'd0, 0, 32'hDEAD_BEEF);
    slot(); issue(1'b1, 1, 3'b000, 5'd2, 1'b1, 32'h203, 32'd0, 1, 32'h80F1_7F00);
    slot(); issue(1'b1, 1, 3'b100, 5'd3, 1'b1, 32'h203, 32'd0, 0, 32'h80F1_7F00);
    slot(); issue(1'b1, 1, 3'b001, 5'd4, 1'b1, 32'h202, 32'd0, 2, 32'h80F1_7F00);
    slot(); issue(1'b1, 1, 3'b101, 5'd6, 1'b1, 32'h200, 32'd0, 0, 32'h80F1_7F00);
    slot(); issue(1'b1, 2, 3'b000, 5'd0, 1'b0, 32'h301, 32'h0000_00AB, 3, 32'd0);
    slot(); issue(1'b1, 1, 3'b010, 5'd8, 1'b1, 32'h102, 32'd0, 0, 32'd0);
    slot(); issue(1'b1, 1, 3'b010, 5'd9, 1'b1, 32'h104, 32'd0, TIMEOUT, 32'd0);
    slot(); issue(1'b1, 0, 3'b000, 5'd5, 1'b1, 32'h1234, 32'd0, 0, 32'd0);
    slot(); issue(1'b1, 1, 3'b010, 5'd10, 1'b1, 32'h108, 32'd0, TIMEOUT - 1, 32'h1357_9BDF);
    slot(); issue(1'b1, 0, 3'b000, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      slot();
      r    = $urandom_range(0, 9);
      ra   = $urandom();
      rdat = $urandom();
      kind = (r == 0) ? -1 : (r <= 3) ? 0 : (r <= 6) ? 1 : 2;
      f3   = (kind == 1) ? load_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      n    = nbytes(f3);
      if (kind > 0 && $urandom_range(0, 9) < 7) ra = ra - (ra % n);
      r = $urandom_range(0, 19);
      lat = (r <= 13) ? $urandom_range(0, 3) : (r <= 16) ? $urandom_range(4, TIMEOUT - 1) :
            (r == 17) ? TIMEOUT - 1 : TIMEOUT;
      if (kind < 0) issue(1'b0, 0, f3, 5'($urandom()), 1'($urandom()), ra, $urandom(), 0, rdat);
      else          issue(1'b1, kind, f3, 5'($urandom()), 1'($urandom()), ra, $urandom(), lat, rdat);
    end
    slot();
    issue(1'b0, 0, 3'd0, 5'd0, 1'b0, 32'd0, 32'd0, 0, 32'd0);

    for (int i = 0; i < 100 && (exp_q.size() != 0 || plan_q.size() != 0 || stall_out); i++)
      @(negedge clk);
    chk("drain_exp_q",  32'(exp_q.size()),  32'd0);
    chk("drain_plan_q", 32'(plan_q.size()), 32'd0);

    // Reset while a load waits; a late ready must not complete anything.
    resp_en = 1'b0;
    slot();
    in_valid = 1'b1; read_mem_from_ex = 1'b1; write_mem_from_ex = 1'b0;
    funct3_from_ex = 3'b010; rd_from_ex = 5'd7; write_reg_from_ex = 1'b1;
    result_from_ex = 32'h400; store_data_from_ex = 32'h5555_AAAA;
    @(negedge clk);
    chk("midrst_req_up", 32'(mem_req), 32'd1);
    in_valid = 1'b0; read_mem_from_ex = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b1;
    force_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_req", 32'(mem_req), 32'd0);
    end
    force_ready = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
